// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a downstream 4:1 mux.
// Grants one of four requesters at a time; each grant lasts at most MAX_HOLD cycles.
module mux4_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic       s1,
   output logic       s0,
   output logic [3:0] gnt,
   output logic       busy
);

   localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [1:0]         g_q, g_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         gnt_d;
   logic [3:0]         mask_req;
   logic [2:0]         win;
   logic               drop;
   logic               limit;

   // Returns {found, index} of the first requester at or after p, wrapping 3->0.
   function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] p);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         idx = p + 2'(i);
         if (r[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         g_q     <= 2'd0;
         cnt_q   <= '0;
         gnt     <= 4'b0000;
         s1      <= 1'b0;
         s0      <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         g_q     <= g_d;
         cnt_q   <= cnt_d;
         gnt     <= gnt_d;
         s1      <= g_d[1];
         s0      <= g_d[0];
         busy    <= (state_d == GRANT);
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      g_d      = g_q;
      cnt_d    = cnt_q;
      mask_req = req;
      win      = 3'b000;
      drop     = !req[g_q];
      limit    = (cnt_q == CNT_W'(MAX_HOLD - 1));

      unique case (state_q)
         IDLE: begin
            win = search(req, ptr_q);
            if (win[2]) begin
               state_d = GRANT;
               g_d     = win[1:0];
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (drop || limit) begin
               // The released index is searched last; masked only when it dropped its request.
               ptr_d = g_q + 2'd1;
               if (drop) mask_req = req & ~(4'b0001 << g_q);
               win = search(mask_req, g_q + 2'd1);
               if (win[2]) begin
                  g_d   = win[1:0];
                  cnt_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      gnt_d = (state_d == GRANT) ? (4'b0001 << g_d) : 4'b0000;
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter (MAX_HOLD=4): directed vectors push expected
// {gnt, s1, s0, busy}; an independent monitor pops and compares after each rising edge.
module tb_mux4_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       s1;
   logic       s0;
   logic [3:0] gnt;
   logic       busy;

   logic [6:0] exp_q[$];
   int         errors;
   int         checks;
   bit         stim_done;

   mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .s1   (s1),
      .s0   (s0),
      .gnt  (gnt),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                       input logic [1:0] es);
      @(negedge clk);
      rst = r;
      req = rq;
      exp_q.push_back({eg, es, |eg});
   endtask

   // Monitor: every cycle with a pending expectation is compared.
   initial begin
      logic [6:0] e;
      logic [6:0] a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {gnt, s1, s0, busy};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL check#%0d t=%0t: got gnt=%b sel=%b busy=%b, want gnt=%b sel=%b busy=%b",
                        checks, $time, a[6:3], a[2:1], a[0], e[6:3], e[2:1], e[0]);
            end
         end
      end
   end

   initial begin
      errors    = 0;
      checks    = 0;
      stim_done = 1'b0;
      rst       = 1'b1;
      req       = 4'b0000;

      // Reset held with all requesting
      repeat (2) step(1'b1, 4'b1111, 4'b0000, 2'b00);
      // Full contention: rotation 0,1,2,3,0 with 4-cycle grants
      repeat (4) step(1'b0, 4'b1111, 4'b0001, 2'b00);
      repeat (4) step(1'b0, 4'b1111, 4'b0010, 2'b01);
      repeat (4) step(1'b0, 4'b1111, 4'b0100, 2'b10);
      repeat (4) step(1'b0, 4'b1111, 4'b1000, 2'b11);
      repeat (4) step(1'b0, 4'b1111, 4'b0001, 2'b00);
      step(1'b0, 4'b0000, 4'b0000, 2'b00);
      // Single request with early drop; select holds in idle
      repeat (2) step(1'b0, 4'b0100, 4'b0100, 2'b10);
      repeat (2) step(1'b0, 4'b0000, 4'b0000, 2'b10);
      // ch3 hits the limit, then 1001 wraps to ch0 and back to ch3
      repeat (4) step(1'b0, 4'b1000, 4'b1000, 2'b11);
      repeat (4) step(1'b0, 4'b1001, 4'b0001, 2'b00);
      step(1'b0, 4'b1001, 4'b1000, 2'b11);
      step(1'b0, 4'b0000, 4'b0000, 2'b11);
      // ch1 released at the limit with 0011: ch1 searched last, ch0 wins
      step(1'b0, 4'b0010, 4'b0010, 2'b01);
      repeat (3) step(1'b0, 4'b0011, 4'b0010, 2'b01);
      step(1'b0, 4'b0011, 4'b0001, 2'b00);
      step(1'b0, 4'b0000, 4'b0000, 2'b00);
      // Lone requester re-granted back-to-back, busy never drops
      repeat (10) step(1'b0, 4'b0001, 4'b0001, 2'b00);
      step(1'b0, 4'b0000, 4'b0000, 2'b00);
      // Late arrival does not preempt ch2; reset mid-grant clears at that edge
      step(1'b0, 4'b0100, 4'b0100, 2'b10);
      repeat (2) step(1'b0, 4'b0101, 4'b0100, 2'b10);
      step(1'b1, 4'b0101, 4'b0000, 2'b00);
      step(1'b0, 4'b0000, 4'b0000, 2'b00);
      // Pointer back at 0 after reset: 0110 goes to ch1
      step(1'b0, 4'b0110, 4'b0010, 2'b01);
      step(1'b0, 4'b0000, 4'b0000, 2'b01);

      stim_done = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: stim_done=%0b after 20000 time units, want 1", stim_done);
      $fatal(1, "timeout");
   end

endmodule
